// File: rtl/trace_capture_buffer_pkg.sv
// Shared sizing constants, FSM encoding and RAM bank indexing for the trace capture buffer.
package trace_pkg;

   localparam int DW           = 8;
   localparam int AW           = 10;
   localparam int DEPTH        = 640;
   localparam int AUTO_TIMEOUT = 2048;

   typedef logic [1:0] state_t;

   localparam state_t ST_ARM     = 2'd0;
   localparam state_t ST_CAPTURE = 2'd1;
   localparam state_t ST_HOLD    = 2'd2;

   // Bank 1 starts at DEPTH, so 2*DEPTH words suffice even when DEPTH < 2**AW.
   function automatic logic [AW:0] bank_index(input logic bank, input logic [AW-1:0] addr);
      return bank ? ((AW+1)'(DEPTH) + {1'b0, addr}) : {1'b0, addr};
   endfunction

endpackage

// File: rtl/trace_capture_buffer_if.sv
// Sample stream from the ADC FIFO reader; read_busy holds off further reads.
interface trace_capture_buffer_if;
   import trace_pkg::*;

   logic [DW-1:0] sample_in;
   logic          sample_valid;
   logic          read_busy;

   modport master (output sample_in, output sample_valid, input read_busy);
   modport slave  (input sample_in, input sample_valid, output read_busy);

endinterface

// File: rtl/trace_bank_ram.sv
// Two-bank trace store, 2*DEPTH x DW: one write port, one registered read port (1-cycle latency).
// Reads beyond DEPTH return 0; no backpressure.
module trace_bank_ram
   import trace_pkg::*;
(
   input  logic          clk,
   input  logic          reset,
   input  logic          wr_en,
   input  logic          wr_bank,
   input  logic [AW-1:0] wr_addr,
   input  logic [DW-1:0] wr_data,
   input  logic          rd_bank,
   input  logic [AW-1:0] rd_addr,
   output logic [DW-1:0] rd_data
);
   logic [DW-1:0] mem [0:2*DEPTH-1];
   logic [AW:0]   wr_idx;
   logic [AW:0]   rd_idx;
   logic          rd_oob;

   assign wr_idx = bank_index(wr_bank, wr_addr);
   assign rd_idx = bank_index(rd_bank, rd_addr);
   assign rd_oob = ({1'b0, rd_addr} >= (AW+1)'(DEPTH));

   always_ff @(posedge clk) begin
      if (wr_en)
         mem[wr_idx] <= wr_data;
   end

   always_ff @(posedge clk) begin
      if (reset || rd_oob)
         rd_data <= '0;
      else
         rd_data <= mem[rd_idx];
   end

endmodule

// File: rtl/trace_capture_buffer.sv
// Triggered single-trace capture into a double-buffered RAM; trace_sample has 1-cycle latency.
// read_busy stalls the FIFO reader from capture end until frame_start swaps banks; TRACE_AUTO_TRIG_EN adds a forced-trigger timeout.
module trace_capture_buffer
   import trace_pkg::*;
(
   input  logic                  clk,
   input  logic                  reset,
   trace_capture_buffer_if.slave smp,
   input  logic [DW-1:0]         trig_level,
   input  logic                  frame_start,
   input  logic [AW-1:0]         pix_x,
   output logic [DW-1:0]         trace_sample,
   output logic                  trace_ready,
   output logic [15:0]           triggered_cnt
);
   state_t        state;
   state_t        state_nxt;
   logic          front;
   logic [AW-1:0] wr_addr;
   logic [AW-1:0] wr_ptr;
   logic [DW-1:0] prev_sample;
   logic          prev_valid;
   logic          busy;
   logic          trig_hit;
   logic          fire;
   logic          wr_en;
   logic          last_wr;

   assign trig_hit = prev_valid && (prev_sample < trig_level) && (smp.sample_in >= trig_level);

`ifdef TRACE_AUTO_TRIG_EN
   localparam int AUTO_CW = $clog2(AUTO_TIMEOUT);
   logic [AUTO_CW-1:0] auto_cnt;

   always_ff @(posedge clk) begin
      if (reset || state != ST_ARM)
         auto_cnt <= '0;
      else if (smp.sample_valid)
         auto_cnt <= auto_cnt + 1'b1;
   end

   assign fire = smp.sample_valid && (trig_hit || auto_cnt == AUTO_CW'(AUTO_TIMEOUT - 1));
`else
   assign fire = smp.sample_valid && trig_hit;
`endif

   assign last_wr       = (wr_addr == AW'(DEPTH - 1));
   assign wr_en         = ((state == ST_ARM) && fire) || ((state == ST_CAPTURE) && smp.sample_valid);
   assign wr_ptr        = (state == ST_ARM) ? '0 : wr_addr;
   assign smp.read_busy = busy;

   always_comb begin
      state_nxt = state;
      case (state)
         ST_ARM:     if (fire) state_nxt = ST_CAPTURE;
         ST_CAPTURE: if (smp.sample_valid && last_wr) state_nxt = ST_HOLD;
         ST_HOLD:    if (frame_start) state_nxt = ST_ARM;
         default:    state_nxt = ST_ARM;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state         <= ST_ARM;
         busy          <= 1'b1;
         front         <= 1'b0;
         wr_addr       <= '0;
         prev_sample   <= '0;
         prev_valid    <= 1'b0;
         trace_ready   <= 1'b0;
         triggered_cnt <= '0;
      end else begin
         state <= state_nxt;
         busy  <= (state_nxt == ST_HOLD);
         case (state)
            ST_ARM: begin
               if (smp.sample_valid) begin
                  prev_sample <= smp.sample_in;
                  prev_valid  <= 1'b1;
               end
               if (fire)
                  wr_addr <= AW'(1);
            end
            ST_CAPTURE: begin
               if (smp.sample_valid) begin
                  if (last_wr) begin
                     wr_addr       <= '0;
                     triggered_cnt <= triggered_cnt + 16'd1;
                  end else begin
                     wr_addr <= wr_addr + 1'b1;
                  end
               end
            end
            ST_HOLD: begin
               // Skid samples are dropped here; only the display swap leaves HOLD.
               if (frame_start) begin
                  front       <= ~front;
                  trace_ready <= 1'b1;
                  prev_valid  <= 1'b0;
               end
            end
            default: ;
         endcase
      end
   end

   trace_bank_ram u_ram (
      .clk     (clk),
      .reset   (reset),
      .wr_en   (wr_en),
      .wr_bank (~front),
      .wr_addr (wr_ptr),
      .wr_data (smp.sample_in),
      .rd_bank (front),
      .rd_addr (pix_x),
      .rd_data (trace_sample)
   );

endmodule

// File: tb/tb_trace_capture_buffer.sv
// Scoreboarded bench for trace_capture_buffer: a behavioural model predicts FSM outputs and bank contents.
module tb_trace_capture_buffer;
   import trace_pkg::*;

   logic          clk = 1'b0;
   logic          reset;
   logic [DW-1:0] trig_level;
   logic          frame_start;
   logic [AW-1:0] pix_x;
   logic [DW-1:0] trace_sample;
   logic          trace_ready;
   logic [15:0]   triggered_cnt;

   trace_capture_buffer_if sif();

   trace_capture_buffer dut (
      .clk           (clk),
      .reset         (reset),
      .smp           (sif),
      .trig_level    (trig_level),
      .frame_start   (frame_start),
      .pix_x         (pix_x),
      .trace_sample  (trace_sample),
      .trace_ready   (trace_ready),
      .triggered_cnt (triggered_cnt)
   );

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   state_t        m_state;
   logic [DW-1:0] m_prev;
   logic          m_prev_vld;
   int            m_auto;
   int            m_cnt;
   logic          m_ready;
   logic [DW-1:0] m_back[$];
   logic [DW-1:0] m_front[$];
   logic [DW-1:0] exp_q[$];

   task automatic model_reset();
      m_state    = ST_ARM;
      m_prev     = '0;
      m_prev_vld = 1'b0;
      m_auto     = 0;
      m_cnt      = 0;
      m_ready    = 1'b0;
      m_back.delete();
      m_front.delete();
   endtask

   task automatic model_step(input logic [DW-1:0] s, input logic v, input logic fs);
      logic fire;
      case (m_state)
         ST_ARM: if (v) begin
            fire = m_prev_vld && (m_prev < trig_level) && (s >= trig_level);
`ifdef TRACE_AUTO_TRIG_EN
            if (m_auto == AUTO_TIMEOUT - 1) fire = 1'b1;
`endif
            if (fire) begin
               m_back.delete();
               m_back.push_back(s);
               m_state = ST_CAPTURE;
               m_auto  = 0;
            end else begin
               m_auto++;
            end
            m_prev     = s;
            m_prev_vld = 1'b1;
         end
         ST_CAPTURE: if (v) begin
            m_back.push_back(s);
            if (m_back.size() == DEPTH) begin
               m_state = ST_HOLD;
               m_cnt++;
            end
         end
         default: if (fs) begin
            m_front    = m_back;
            m_ready    = 1'b1;
            m_prev_vld = 1'b0;
            m_state    = ST_ARM;
         end
      endcase
   endtask

   // Drives one clock of stimulus, advances the model, and returns #1 after the edge.
   task automatic cycle(input logic [DW-1:0] s, input logic v, input logic fs);
      sif.sample_in    = s;
      sif.sample_valid = v;
      frame_start      = fs;
      model_step(s, v, fs);
      @(posedge clk);
      #1;
      frame_start      = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      n_tests++;
      if (sif.read_busy !== 1'b1 || trace_ready !== 1'b0 || triggered_cnt !== 16'd0 || trace_sample !== 8'd0) begin
         n_fail++;
         $display("FAIL reset_values: busy=%b ready=%b cnt=%0d sample=%0d, want 1 0 0 0",
                  sif.read_busy, trace_ready, triggered_cnt, trace_sample);
      end
      reset = 1'b0;
      model_reset();
      cycle(8'd0, 1'b0, 1'b0);
      n_tests++;
      if (sif.read_busy !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_release_busy: read_busy=%b want 0", sif.read_busy);
      end
   endtask

   task automatic test_capture();
      int k = 0;
      int c = 0;
      trig_level = 8'd128;
      while (m_state != ST_HOLD && c < 2000) begin
         if (c % 5 == 4) cycle(8'hFF, 1'b0, 1'b0);
         else begin
            cycle(8'((k % 26) * 10), 1'b1, 1'b0);
            k++;
         end
         c++;
         n_tests++;
         if (sif.read_busy !== (m_state == ST_HOLD)) begin
            n_fail++;
            $display("FAIL capture_busy cyc=%0d: read_busy=%b want %b", c, sif.read_busy, m_state == ST_HOLD);
         end
      end
      n_tests++;
      if (m_state != ST_HOLD || triggered_cnt !== 16'd1 || sif.read_busy !== 1'b1) begin
         n_fail++;
         $display("FAIL capture_done: cnt=%0d busy=%b want 1 1 (model hold=%b)", triggered_cnt, sif.read_busy, m_state == ST_HOLD);
      end
      for (int i = 0; i < 2; i++) begin
         cycle(8'hEE, 1'b1, 1'b0);
         n_tests++;
         if (sif.read_busy !== 1'b1 || triggered_cnt !== 16'd1) begin
            n_fail++;
            $display("FAIL skid_discard %0d: busy=%b cnt=%0d want 1 1", i, sif.read_busy, triggered_cnt);
         end
      end
   endtask

   task automatic test_readout(input string tag);
      logic [DW-1:0] exp;
      for (int p = 0; p <= DEPTH; p++) begin
         pix_x = (p == DEPTH) ? AW'(700) : AW'(p);
         exp_q.push_back((p == DEPTH) ? 8'd0 : m_front[p]);
         cycle(8'd0, 1'b0, 1'b0);
         exp = exp_q.pop_front();
         n_tests++;
         if (trace_sample !== exp) begin
            n_fail++;
            $display("FAIL %s pix=%0d: trace_sample=%0d want %0d", tag, pix_x, trace_sample, exp);
         end
      end
   endtask

   task automatic test_swap(input logic [DW-1:0] first_val);
      cycle(8'd0, 1'b0, 1'b1);
      n_tests++;
      if (trace_ready !== 1'b1 || sif.read_busy !== 1'b0) begin
         n_fail++;
         $display("FAIL swap: ready=%b busy=%b want 1 0", trace_ready, sif.read_busy);
      end
      pix_x = '0;
      cycle(8'd0, 1'b0, 1'b0);
      n_tests++;
      if (trace_sample !== first_val) begin
         n_fail++;
         $display("FAIL swap_first_sample: trace_sample=%0d want %0d", trace_sample, first_val);
      end
      test_readout("swap_readout");
   endtask

   task automatic test_frame_in_capture();
      int k = 0;
      int c = 0;
      bit pulsed = 0;
      logic fs;
      while (m_state != ST_HOLD && c < 2000) begin
         fs = (m_state == ST_CAPTURE && m_back.size() == 300 && !pulsed);
         if (fs) pulsed = 1;
         cycle(8'((k % 64) * 4), 1'b1, fs);
         k++;
         c++;
         n_tests++;
         if (sif.read_busy !== (m_state == ST_HOLD) || trace_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL frame_in_capture cyc=%0d: busy=%b ready=%b want %b 1", c, sif.read_busy, trace_ready, m_state == ST_HOLD);
         end
      end
      n_tests++;
      if (triggered_cnt !== 16'(m_cnt) || !pulsed) begin
         n_fail++;
         $display("FAIL frame_in_capture_done: cnt=%0d want %0d pulsed=%0d", triggered_cnt, m_cnt, pulsed);
      end
      test_readout("front_unchanged");
      test_swap(8'd128);
   endtask

   task automatic test_flat_level();
      for (int i = 0; i < 2100; i++) begin
         cycle(8'd128, 1'b1, 1'b0);
         n_tests++;
         if (sif.read_busy !== (m_state == ST_HOLD) || triggered_cnt !== 16'(m_cnt)) begin
            n_fail++;
            $display("FAIL flat_level i=%0d: busy=%b cnt=%0d want %b %0d", i, sif.read_busy, triggered_cnt, m_state == ST_HOLD, m_cnt);
         end
      end
`ifdef TRACE_AUTO_TRIG_EN
      n_tests++;
      if (sif.read_busy !== 1'b0 || dut.state !== ST_CAPTURE) begin
         n_fail++;
         $display("FAIL auto_trigger: busy=%b state=%0d want 0 %0d", sif.read_busy, dut.state, ST_CAPTURE);
      end
`endif
   endtask

   task automatic test_reset_mid_capture();
      int k = 0;
      int c = 0;
      while (!(m_state == ST_CAPTURE && m_back.size() == 100) && c < 5000) begin
         cycle(8'((k % 64) * 4), 1'b1, m_state == ST_HOLD);
         k++;
         c++;
      end
      reset = 1'b1;
      sif.sample_valid = 1'b0;
      @(posedge clk);
      #1;
      n_tests++;
      if (sif.read_busy !== 1'b1 || trace_ready !== 1'b0 || triggered_cnt !== 16'd0) begin
         n_fail++;
         $display("FAIL mid_reset: busy=%b ready=%b cnt=%0d want 1 0 0", sif.read_busy, trace_ready, triggered_cnt);
      end
      reset = 1'b0;
      model_reset();
      cycle(8'd0, 1'b0, 1'b0);
      n_tests++;
      if (sif.read_busy !== 1'b0 || trace_ready !== 1'b0) begin
         n_fail++;
         $display("FAIL mid_reset_release: busy=%b ready=%b want 0 0", sif.read_busy, trace_ready);
      end
      k = 0;
      c = 0;
      while (m_state != ST_HOLD && c < 2000) begin
         cycle(8'((k % 26) * 10), 1'b1, 1'b0);
         k++;
         c++;
      end
      n_tests++;
      if (sif.read_busy !== 1'b1 || triggered_cnt !== 16'd1) begin
         n_fail++;
         $display("FAIL post_reset_capture: busy=%b cnt=%0d want 1 1", sif.read_busy, triggered_cnt);
      end
      test_swap(8'd130);
   endtask

   initial begin
      reset            = 1'b1;
      trig_level       = 8'd128;
      frame_start      = 1'b0;
      pix_x            = '0;
      sif.sample_in    = '0;
      sif.sample_valid = 1'b0;
      model_reset();
      test_reset();
      test_capture();
      test_swap(8'd130);
      test_frame_in_capture();
      test_flat_level();
      test_reset_mid_capture();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #500_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule
